spi_dac_receiver: RTL
=====================

// Module: spi_dac_receiver
// PURPOSE
//  SPI responder (DAC end of the link): deserialises frames driven by the SPI master on sclk/cs_n/mosi.
//  All SPI inputs are oversampled in the clk_in domain; no logic is clocked by sclk.
//  Delivers each complete word as a one-cycle rx_valid strobe to the DAC register model.
//  Truncated frames are flagged. Serves as DUT-side model and as on-chip loopback checker.
// PARAMETERS
//  WORD_W       16  bits per frame, MSB first.
//  SYNC_STAGES   2  flops per input synchroniser, minimum 2.
// PORTS
//  clk_in     in   1       system clock (96 MHz); sclk must be <= clk_in/8.
//  reset      in   1       asynchronous, active-high; clears all state.
//  sclk       in   1       SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk_in.
//  cs_n       in   1       chip select, active-low, frames the transfer.
//  mosi       in   1       serial data, sampled on rising sclk.
//  rx_data    out  WORD_W  last complete word; held until next complete frame.
//  rx_valid   out  1       one-cycle strobe: rx_data updated.
//  frame_err  out  1       one-cycle strobe: frame closed with bit count != WORD_W.
//  busy       out  1       high while FSM is in SHIFT or FULL.
//  miso       out  1       readback data (SPI_RX_MISO_EN only; else tied 0).
// BEHAVIOUR
//  Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, miso=0, bit_cnt=0, state=ARM.
//  Sync: sclk/cs_n/mosi pass SYNC_STAGES flops; one more flop gives sclk_rise/sclk_fall and cs_rise/cs_fall.
//  Synchroniser flops reset to sclk=0, cs_n=1, mosi=0.
//  FSM:
//   ARM   : after reset; wait for synced cs_n=1, then IDLE. A frame in progress at reset release is ignored.
//   IDLE  : cs_fall -> SHIFT, bit_cnt=0, shift reg=0.
//   SHIFT : on sclk_rise, shift = {shift[WORD_W-2:0], mosi_s}, bit_cnt++; at bit_cnt==WORD_W -> FULL.
//   FULL  : further sclk_rise ignored; bit_cnt saturates at WORD_W+1 (overrun marker).
//  Frame close: cs_rise in SHIFT or FULL -> IDLE.
//   bit_cnt==WORD_W   : rx_data<=shift, rx_valid=1 on the next clk_in cycle.
//   bit_cnt!=WORD_W   : frame_err=1 on the next clk_in cycle; rx_data unchanged.
//   The overrun case (WORD_W+1) counts as !=WORD_W.
//  Latency: raw cs_n rise -> rx_valid = SYNC_STAGES+2 clk_in cycles.
//  Simultaneous sclk_rise and cs_rise in the same cycle: cs_rise wins; the bit is not shifted.
//  cs_fall seen in SHIFT/FULL cannot occur without cs_rise; cs glitch < 1 clk_in cycle is not detected.
//  rx_valid and frame_err are mutually exclusive and never high two consecutive cycles.
//  Async reset mid-frame: outputs clear immediately; state goes to ARM; the partial frame is dropped silently.
//  busy = (state==SHIFT || state==FULL).
// CONFIGURATION
//  SPI_RX_MISO_EN defined: tx shift reg loads rx_data at cs_fall.
//   miso = tx[WORD_W-1] while cs_n low.
//   tx shifts left on sclk_fall; miso=0 when cs_n high.
//   The master reads back the previous word.
//  SPI_RX_MISO_EN undefined: no tx register; miso is driven constant 0.
// STRUCTURE
//  Package spi_dac_pkg:
//   state enum {ARM, IDLE, SHIFT, FULL} (2 bits).
//   SPI_WORD_W_DEF=16.
//   SPI_CNT_W = $clog2(WORD_W+2).
//  Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus edge flop.
//   Outputs sig_s, rise, fall; one instance each for sclk, cs_n, mosi (mosi edges unused).
//  Top level: FSM, bit counter, shift register, output registers.
// TESTING
//  1 Reset release with cs_n=1; then frame 0xA5C3, sclk=clk_in/96.
//    -> rx_data=0xA5C3, one rx_valid pulse SYNC_STAGES+2 cycles after cs_n rise; frame_err stays 0.
//  2 Frame with 12 clocks then cs_n rise.
//    -> frame_err pulse; rx_data keeps prior 0xA5C3; no rx_valid.
//  3 Frame with 17 clocks (0xFFFF then extra 0).
//    -> state FULL after bit 16; frame_err at close; rx_data unchanged.
//  4 reset asserted after bit 8, released while cs_n still low, then remaining bits clocked.
//    -> no rx_valid and no frame_err for that frame; the next clean frame 0x0001 gives rx_valid.
//  5 Back-to-back frames 0x1234 and 0x8000 with 2 clk_in of cs_n high between them.
//    -> two rx_valid pulses with data 0x1234 then 0x8000.
//  6 SPI_RX_MISO_EN defined: frame 0x1234 then frame 0x0000.
//    -> miso bits of the second frame read 0x1234 MSB first; miso=0 while cs_n high.

Source files
------------

// File: rtl/spi_dac_receiver_pkg.sv
// spi_dac_pkg: shared types and sizing for the SPI DAC receiver
package spi_dac_pkg;
  localparam int SPI_WORD_W_DEF = 16;
  localparam int SPI_CNT_W = $clog2(SPI_WORD_W_DEF + 2);
  typedef enum logic [1:0] {ARM, IDLE, SHIFT, FULL} spi_state_e;
  function automatic int spi_cnt_w(input int word_w);
    return $clog2(word_w + 2);
  endfunction
endpackage

// File: rtl/spi_dac_receiver_if.sv
// spi_dac_receiver_if: SPI pins plus received-word outputs
// master: drives sclk/cs_n/mosi, observes miso and receiver outputs
// slave : the receiver side
interface spi_dac_receiver_if #(parameter int WORD_W = spi_dac_pkg::SPI_WORD_W_DEF);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              busy;
  modport master (output sclk, cs_n, mosi, input miso, rx_data, rx_valid, frame_err, busy);
  modport slave  (input sclk, cs_n, mosi, output miso, rx_data, rx_valid, frame_err, busy);
endinterface

// File: rtl/spi_dac_receiver_sync_edge.sv
// spi_sync_edge: STAGES-flop synchroniser followed by one edge-detect flop
// ports: clk_in, reset (async, active-high), d_i raw input,
//        sig_s_o synced level, rise_o / fall_o one-cycle edge strobes aligned with sig_s_o
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic reset,
  input  logic d_i,
  output logic sig_s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              sig_q, rise_q, fall_q;
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      sig_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      sig_q  <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~sig_q;
      fall_q <= ~sync_q[STAGES-1] & sig_q;
    end
  assign sig_s_o = sig_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/spi_dac_receiver.sv
// spi_dac_receiver: oversampled SPI mode-0 responder delivering WORD_W-bit words
// ports: clk_in, reset (async, active-high), bus (spi_dac_receiver_if.slave):
//        sclk/cs_n/mosi in; rx_data, rx_valid, frame_err, busy, miso out
// SPI_RX_MISO_EN: when defined, miso returns the previously received word
module spi_dac_receiver
  import spi_dac_pkg::*;
#(
  parameter int WORD_W      = SPI_WORD_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 reset,
  spi_dac_receiver_if.slave    bus
);
  localparam int CNT_W = spi_cnt_w(WORD_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(SYNC_STAGES + 1);
  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  spi_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d, rx_data_q;
  logic              rx_valid_q, frame_err_q;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk_in(clk_in), .reset(reset), .d_i(bus.sclk), .sig_s_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk_in(clk_in), .reset(reset), .d_i(bus.cs_n), .sig_s_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk_in(clk_in), .reset(reset), .d_i(bus.mosi), .sig_s_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));
  assign cnt_d   = cnt_q + 1'b1;
  assign shift_d = {shift_q[WORD_W-2:0], mosi_s};
  // ARM holds until cs_n has read high for longer than the synchroniser's
  // reset-value window, so a frame already running at reset release is dropped.
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      state_q     <= ARM;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ARM: begin
          cnt_q <= cs_s ? cnt_d : '0;
          if (cs_s && cnt_q == CNT_ARM) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        IDLE:
          if (cs_fall) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            shift_q <= '0;
          end
        SHIFT, FULL:
          if (cs_rise) begin
            state_q     <= IDLE;
            rx_valid_q  <= cnt_q == CNT_FULL;
            frame_err_q <= cnt_q != CNT_FULL;
            if (cnt_q == CNT_FULL) rx_data_q <= shift_q;
          end else if (sclk_rise) begin
            if (state_q == SHIFT) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_d;
              if (cnt_d == CNT_FULL) state_q <= FULL;
            end else cnt_q <= CNT_OVR;
          end
        default: state_q <= ARM;
      endcase
    end
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = state_q == SHIFT || state_q == FULL;
`ifdef SPI_RX_MISO_EN
  logic [WORD_W-1:0] tx_q;
  logic              unused_edges;
  always_ff @(posedge clk_in or posedge reset)
    if (reset) tx_q <= '0;
    else if (cs_fall) tx_q <= rx_data_q;
    else if (!cs_s && sclk_fall) tx_q <= {tx_q[WORD_W-2:0], 1'b0};
  assign bus.miso     = ~cs_s & tx_q[WORD_W-1];
  assign unused_edges = mosi_rise ^ mosi_fall ^ sclk_s;
`else
  logic unused_edges;
  assign bus.miso     = 1'b0;
  assign unused_edges = mosi_rise ^ mosi_fall ^ sclk_fall ^ sclk_s;
`endif
endmodule
